mm_tile_controller: RTL and testbench
=====================================

Name: mm_tile_controller

Overview:
- Parametrised successor to the fixed 8x8 matmul controller.
- Walks a C = A·B product as SA_SIZE x SA_SIZE output tiles. For each tile it issues the global-buffer read addresses (A, B), the systolic feed, bubble and drain controls, and the result write-back addresses (P).
- Sits between the host/AXI-lite register block (dims, base addresses, start) and the global buffers plus systolic array.

Parameters:
- ADDR_WIDTH, 16, width of dims, base addresses and buffer addresses.
- SA_SIZE, 8, systolic array edge; power of two, 2..64.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  level start; sampled only in IDLE/DONE
- valid_o  out  1  high in DONE
- busy_o  out  1  high in FEED/DRAIN/WRITE
- m_i, k_i, n_i  in  ADDR_WIDTH each  matrix dims (A is m x k, B is k x n)
- base_addra_i, base_addrb_i, base_addrp_i  in  ADDR_WIDTH each  buffer base addresses
- batch_begin_o  out  1  pulse, first FEED cycle of each tile
- batch_end_o  out  1  pulse, last WRITE cycle of each tile
- ensys_o  out  1  systolic array advance enable
- bubble_o  out  1  inject zeros into the array this cycle
- ena_o  out  1  buffer A read enable
- addra_o  out  ADDR_WIDTH  buffer A address
- enb_o  out  1  buffer B read enable
- addrb_o  out  ADDR_WIDTH  buffer B address
- enp_o  out  1  buffer P enable
- wep_o  out  1  buffer P write enable
- addrp_o  out  ADDR_WIDTH  buffer P address

Behaviour:
- Reset (asynchronous, any state, mid-tile included): state=IDLE, all counters 0, every output 0. No further buffer access until the next start.
- Latching: dims and bases are latched on the IDLE->FEED transition; later input changes are ignored until the next run.
- Derived values (all modulo 2^ADDR_WIDTH):
  - R = ceil(m/SA_SIZE), C = ceil(n/SA_SIZE).
  - K = max(k, SA_SIZE).
  - Tile order: row batch r outer, col batch c inner.
- States: IDLE, FEED, DRAIN, WRITE, DONE.
- IDLE:
  - start_i=1 with m, k, n all nonzero -> FEED at r=c=0.
  - start_i=1 with any dim zero -> DONE directly; no buffer access.
- FEED, K cycles, t = 0..K-1:
  - ensys_o=1 on every FEED cycle.
  - t<k: ena_o=enb_o=1, addra_o = base_a + r·k + t, addrb_o = base_b + c·k + t, bubble_o=0.
  - t>=k: ena_o=enb_o=0, bubble_o=1.
  - batch_begin_o=1 at t=0.
- DRAIN, 2·SA_SIZE-1 cycles: ensys_o=1, bubble_o=1, no buffer enables.
- WRITE, SA_SIZE cycles, i = 0..SA_SIZE-1:
  - ensys_o=0; enp_o=wep_o=1.
  - addrp_o = base_p + (r·C + c)·SA_SIZE + i.
  - batch_end_o=1 at the last cycle.
  - After the last cycle: c+1<C -> FEED with c+1; else r+1<R -> FEED with c=0, r+1; else -> DONE.
- DONE: valid_o=1; start_i=0 -> IDLE, otherwise remain in DONE (no retrigger while start is held).
- start_i is ignored in FEED/DRAIN/WRITE.
- Address arithmetic: offsets are held as running sums (add k per row batch, add k per col batch, add SA_SIZE per tile), not multipliers. Overflow wraps silently.
- All outputs are registered-state-decoded: they change only on clk_i edges.

Decomposition:
- Package mm_pkg: state encodings (IDLE..DONE), default ADDR_WIDTH and SA_SIZE, function clog2.
- Sub-module mm_tile_iter: nested r/c tile counter. Takes R, C and an advance input; outputs r, c, running A/B/P offsets and a last_tile flag.
- The FSM and phase counter t/i stay in mm_tile_controller.

Test Plan (SA_SIZE=8, ADDR_WIDTH=16; start sampled at cycle 0):
- m=k=n=8, bases 0x000/0x100/0x200:
  - FEED at cycles 1-8, addra 0..7, addrb 0x100..0x107, batch_begin at cycle 1.
  - DRAIN at cycles 9-23.
  - WRITE at cycles 24-31, addrp 0x200..0x207, batch_end at cycle 31.
  - valid_o=1 from cycle 32.
- m=16, n=16, k=4, bases 0:
  - Four tiles in order (0,0),(0,1),(1,0),(1,1).
  - Each FEED: ena 4 cycles then bubble 4 cycles.
  - Tile (1,0) addra starts at 4; tile (0,1) addrb starts at 4.
  - addrp bases are 0, 8, 16, 24.
- k=0, m=n=8: DONE at cycle 1; ena/enb/enp never asserted.
- Assert rst_i at cycle 12 of the first scenario: outputs 0 the same cycle; after release, remains IDLE until start.
- Hold start_i=1 through DONE for 10 cycles: valid_o stays 1, no new FEED. Drop start_i: IDLE next cycle, valid_o=0.
- m=9: R=2; second row-batch addra = base_a + k; 2 full tiles written.

Source files
------------

// File: rtl/mm_tile_controller_pkg.sv
// Shared types and constants for the tiled matmul controller.
// Holds state encodings, default sizes and a clog2 helper.
package mm_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int SA_SIZE_DEF    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_tile_controller_if.sv
// Global-buffer access bus: A/B read ports and P write port.
// master = controller side, slave = buffer side.
interface mm_buf_if #(
    parameter int AW = 16
);
    logic          ena;
    logic [AW-1:0] addra;
    logic          enb;
    logic [AW-1:0] addrb;
    logic          enp;
    logic          wep;
    logic [AW-1:0] addrp;

    modport master (
        output ena, addra, enb, addrb, enp, wep, addrp
    );

    modport slave (
        input ena, addra, enb, addrb, enp, wep, addrp
    );
endinterface

// File: rtl/mm_tile_controller_iter.sv
// Nested tile iterator: r outer, c inner, with running A/B/P offsets.
// Ports: clear_i restarts at (0,0); adv_i steps to the next tile.
module mm_tile_iter
    import mm_pkg::*;
#(
    parameter int AW = ADDR_WIDTH_DEF,
    parameter int SA_SIZE = SA_SIZE_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          adv_i,
    input  logic [AW-1:0] rows_i,
    input  logic [AW-1:0] cols_i,
    input  logic [AW-1:0] k_i,
    output logic [AW-1:0] r_o,
    output logic [AW-1:0] c_o,
    output logic [AW-1:0] offa_o,
    output logic [AW-1:0] offb_o,
    output logic [AW-1:0] offp_o,
    output logic          last_o
);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] SA  = AW'(SA_SIZE);

    logic [AW-1:0] r_q, r_d, c_q, c_d;
    logic [AW-1:0] oa_q, oa_d, ob_q, ob_d, op_q, op_d;
    logic          c_wrap;

    assign c_wrap = (c_q + ONE) == cols_i;

    always_comb begin
        r_d  = r_q;
        c_d  = c_q;
        oa_d = oa_q;
        ob_d = ob_q;
        op_d = op_q;
        if (clear_i) begin
            r_d  = '0;
            c_d  = '0;
            oa_d = '0;
            ob_d = '0;
            op_d = '0;
        end else if (adv_i) begin
            op_d = op_q + SA;
            if (c_wrap) begin
                c_d  = '0;
                ob_d = '0;
                r_d  = r_q + ONE;
                oa_d = oa_q + k_i;
            end else begin
                c_d  = c_q + ONE;
                ob_d = ob_q + k_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q  <= '0;
            c_q  <= '0;
            oa_q <= '0;
            ob_q <= '0;
            op_q <= '0;
        end else begin
            r_q  <= r_d;
            c_q  <= c_d;
            oa_q <= oa_d;
            ob_q <= ob_d;
            op_q <= op_d;
        end
    end

    assign r_o    = r_q;
    assign c_o    = c_q;
    assign offa_o = oa_q;
    assign offb_o = ob_q;
    assign offp_o = op_q;
    assign last_o = c_wrap && ((r_q + ONE) == rows_i);

endmodule

// File: rtl/mm_tile_controller.sv
// Tiled C = A*B controller: FEED/DRAIN/WRITE per SA_SIZE^2 output tile.
// Ports: start/dims/bases in; valid/busy/batch/systolic ctl out; bufs_o bus.
module mm_tile_controller
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int SA_SIZE = SA_SIZE_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  valid_o,
    output logic                  busy_o,
    input  logic [ADDR_WIDTH-1:0] m_i,
    input  logic [ADDR_WIDTH-1:0] k_i,
    input  logic [ADDR_WIDTH-1:0] n_i,
    input  logic [ADDR_WIDTH-1:0] base_addra_i,
    input  logic [ADDR_WIDTH-1:0] base_addrb_i,
    input  logic [ADDR_WIDTH-1:0] base_addrp_i,
    output logic                  batch_begin_o,
    output logic                  batch_end_o,
    output logic                  ensys_o,
    output logic                  bubble_o,
    mm_buf_if.master              bufs_o
);
    localparam int AW  = ADDR_WIDTH;
    localparam int LOG = clog2(SA_SIZE);
    localparam logic [AW-1:0] ONE   = AW'(1);
    localparam logic [AW-1:0] SA    = AW'(SA_SIZE);
    localparam logic [AW-1:0] DLAST = AW'(2 * SA_SIZE - 2);
    localparam logic [AW-1:0] WLAST = AW'(SA_SIZE - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ph_q, ph_d;
    logic [AW-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [AW-1:0] ba_q, ba_d, bb_q, bb_d, bp_q, bp_d;

    logic [AW-1:0] rows, cols, kmax;
    logic [AW:0]   m_ext, n_ext;
    logic [AW-1:0] offa, offb, offp;
    logic [AW-1:0] r_unused, c_unused;
    logic          last_tile, it_clear, it_adv, zero_dim;

    // Ceiling divide in AW+1 bits so m near 2^AW cannot wrap.
    assign m_ext = {1'b0, m_q} + (AW+1)'(SA_SIZE - 1);
    assign n_ext = {1'b0, n_q} + (AW+1)'(SA_SIZE - 1);
    assign rows  = AW'(m_ext >> LOG);
    assign cols  = AW'(n_ext >> LOG);
    assign kmax  = (k_q < SA) ? SA : k_q;

    assign zero_dim = (m_i == '0) || (k_i == '0) || (n_i == '0);
    assign it_clear = (state_q == S_IDLE) && start_i;
    assign it_adv   = (state_q == S_WRITE) && (ph_q == WLAST) && !last_tile;

    mm_tile_iter #(
        .AW      (AW),
        .SA_SIZE (SA_SIZE)
    ) u_iter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (it_clear),
        .adv_i   (it_adv),
        .rows_i  (rows),
        .cols_i  (cols),
        .k_i     (k_q),
        .r_o     (r_unused),
        .c_o     (c_unused),
        .offa_o  (offa),
        .offb_o  (offb),
        .offp_o  (offp),
        .last_o  (last_tile)
    );

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        m_d     = m_q;
        k_d     = k_q;
        n_d     = n_q;
        ba_d    = ba_q;
        bb_d    = bb_q;
        bp_d    = bp_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ph_d = '0;
                    if (zero_dim) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FEED;
                        m_d  = m_i;
                        k_d  = k_i;
                        n_d  = n_i;
                        ba_d = base_addra_i;
                        bb_d = base_addrb_i;
                        bp_d = base_addrp_i;
                    end
                end
            end
            S_FEED: begin
                ph_d = ph_q + ONE;
                if (ph_q == kmax - ONE) begin
                    state_d = S_DRAIN;
                    ph_d    = '0;
                end
            end
            S_DRAIN: begin
                ph_d = ph_q + ONE;
                if (ph_q == DLAST) begin
                    state_d = S_WRITE;
                    ph_d    = '0;
                end
            end
            S_WRITE: begin
                ph_d = ph_q + ONE;
                if (ph_q == WLAST) begin
                    state_d = last_tile ? S_DONE : S_FEED;
                    ph_d    = '0;
                end
            end
            S_DONE: begin
                if (!start_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            ba_q    <= '0;
            bb_q    <= '0;
            bp_q    <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            m_q     <= m_d;
            k_q     <= k_d;
            n_q     <= n_d;
            ba_q    <= ba_d;
            bb_q    <= bb_d;
            bp_q    <= bp_d;
        end
    end

    // Outputs decode registered state only; addresses are zero when idle.
    always_comb begin
        valid_o       = 1'b0;
        busy_o        = 1'b0;
        batch_begin_o = 1'b0;
        batch_end_o   = 1'b0;
        ensys_o       = 1'b0;
        bubble_o      = 1'b0;
        bufs_o.ena    = 1'b0;
        bufs_o.addra  = '0;
        bufs_o.enb    = 1'b0;
        bufs_o.addrb  = '0;
        bufs_o.enp    = 1'b0;
        bufs_o.wep    = 1'b0;
        bufs_o.addrp  = '0;
        unique case (state_q)
            S_FEED: begin
                busy_o        = 1'b1;
                ensys_o       = 1'b1;
                batch_begin_o = (ph_q == '0);
                if (ph_q < k_q) begin
                    bufs_o.ena   = 1'b1;
                    bufs_o.enb   = 1'b1;
                    bufs_o.addra = ba_q + offa + ph_q;
                    bufs_o.addrb = bb_q + offb + ph_q;
                end else begin
                    bubble_o = 1'b1;
                end
            end
            S_DRAIN: begin
                busy_o   = 1'b1;
                ensys_o  = 1'b1;
                bubble_o = 1'b1;
            end
            S_WRITE: begin
                busy_o       = 1'b1;
                bufs_o.enp   = 1'b1;
                bufs_o.wep   = 1'b1;
                bufs_o.addrp = bp_q + offp + ph_q;
                batch_end_o  = (ph_q == WLAST);
            end
            S_DONE:  valid_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mm_tile_controller.sv
// Directed bench for mm_tile_controller (SA_SIZE=8, ADDR_WIDTH=16).
// Walks reset, single/multi-tile runs, zero dims and DONE hold.
module tb_mm_tile_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid, busy, bbeg, bend, ensys, bubble;
    logic [15:0] m = '0, k = '0, n = '0;
    logic [15:0] ba = '0, bb = '0, bp = '0;
    int          n_pass = 0;
    int          n_total = 0;

    mm_buf_if #(.AW(16)) bif ();

    mm_tile_controller #(
        .ADDR_WIDTH (16),
        .SA_SIZE    (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .valid_o       (valid),
        .busy_o        (busy),
        .m_i           (m),
        .k_i           (k),
        .n_i           (n),
        .base_addra_i  (ba),
        .base_addrb_i  (bb),
        .base_addrp_i  (bp),
        .batch_begin_o (bbeg),
        .batch_end_o   (bend),
        .ensys_o       (ensys),
        .bubble_o      (bubble),
        .bufs_o        (bif)
    );

    always #5 clk = ~clk;

    // {valid,busy,bbeg,bend,ensys,bubble,ena,enb,enp,wep}
    wire [9:0] flags = {valid, busy, bbeg, bend, ensys, bubble,
                        bif.ena, bif.enb, bif.enp, bif.wep};

    function automatic logic [9:0] fv(
        input bit v, bs, b0, b1, es, bu, ea, eb, ep, wp);
        return {v, bs, b0, b1, es, bu, ea, eb, ep, wp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tile(input int r, c, kk, cc,
                        input int a0, b0, p0);
        int kx;
        logic [15:0] ea;
        kx = (kk < 8) ? 8 : kk;
        for (int t = 0; t < kx; t++) begin
            step();
            chk("feed_flags", 32'(flags),
                32'(fv(0, 1, t == 0, 0, 1, t >= kk,
                       t < kk, t < kk, 0, 0)));
            if (t < kk) begin
                ea = 16'(a0 + r * kk + t);
                chk("addra", 32'(bif.addra), 32'(ea));
                ea = 16'(b0 + c * kk + t);
                chk("addrb", 32'(bif.addrb), 32'(ea));
            end
        end
        for (int d = 0; d < 15; d++) begin
            step();
            chk("drain_flags", 32'(flags),
                32'(fv(0, 1, 0, 0, 1, 1, 0, 0, 0, 0)));
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk("write_flags", 32'(flags),
                32'(fv(0, 1, 0, i == 7, 0, 0, 0, 0, 1, 1)));
            ea = 16'(p0 + (r * cc + c) * 8 + i);
            chk("addrp", 32'(bif.addrp), 32'(ea));
        end
    endtask

    task automatic setup(input int mm, kk, nn, a0, b0, p0);
        m  = 16'(mm);
        k  = 16'(kk);
        n  = 16'(nn);
        ba = 16'(a0);
        bb = 16'(b0);
        bp = 16'(p0);
    endtask

    initial begin
        // reset state
        #1;
        chk("reset_async", 32'(flags), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_flags", 32'(flags), 32'd0);

        // 8x8x8 single tile, start held throughout
        setup(8, 8, 8, 'h000, 'h100, 'h200);
        start = 1'b1;
        tile(0, 0, 8, 1, 'h000, 'h100, 'h200);
        for (int j = 0; j < 10; j++) begin
            step();
            chk("done_hold", 32'(flags),
                32'(fv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        end
        start = 1'b0;
        step();
        chk("done_to_idle", 32'(flags), 32'd0);

        // async reset mid-run (cycle 12, in DRAIN)
        start = 1'b1;
        for (int j = 0; j < 11; j++) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_midrun", 32'(flags), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("post_rst_idle", 32'(flags), 32'd0);
        end

        // zero k -> DONE directly, no buffer access
        setup(8, 0, 8, 0, 0, 0);
        start = 1'b1;
        step();
        chk("zero_k_done", 32'(flags),
            32'(fv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        start = 1'b0;
        step();
        chk("zero_k_idle", 32'(flags), 32'd0);

        // 16x4x16: four tiles, inputs scrambled after latch
        setup(16, 4, 16, 0, 0, 0);
        start = 1'b1;
        tile(0, 0, 4, 2, 0, 0, 0);
        start = 1'b0;
        setup(1, 1, 1, 'hffff, 'hffff, 'hffff);
        tile(0, 1, 4, 2, 0, 0, 0);
        tile(1, 0, 4, 2, 0, 0, 0);
        tile(1, 1, 4, 2, 0, 0, 0);
        step();
        chk("four_tile_done", 32'(flags),
            32'(fv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        step();
        chk("four_tile_idle", 32'(flags), 32'd0);

        // m=9: two row batches
        setup(9, 8, 8, 'h10, 'h20, 'h30);
        start = 1'b1;
        tile(0, 0, 8, 1, 'h10, 'h20, 'h30);
        start = 1'b0;
        tile(1, 0, 8, 1, 'h10, 'h20, 'h30);
        step();
        chk("m9_done", 32'(flags),
            32'(fv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
